// File: rtl/muldiv_seq.sv
// muldiv_seq: sequences M-extension ops from the EX stage through an iterative
// multiply/divide unit. It stalls the front of the pipeline while the unit
// works, handles flushes of the in-flight op, and guards against a unit that
// never answers with a sticky watchdog timeout.
// Optional build macro: MULDIV_DIV0_SHORTCUT_EN -- when defined, divide and
// remainder by zero are answered straight from IDLE without starting the unit.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic        flush_i,
    output logic        unit_start_o,
    output logic [2:0]  unit_op_o,
    output logic [31:0] unit_a_o,
    output logic [31:0] unit_b_o,
    input  logic        unit_done_i,
    input  logic [31:0] unit_result_i,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // The watchdog starts at 0 on entry, so value 62 marks the 63rd waiting cycle.
    localparam logic [5:0] WDOG_LAST = 6'd62;

    state_t      state;
    logic [5:0]  wdog;
    logic        valid_q;
    logic        accept;
    logic        div0;

    // A request is taken only in IDLE, never alongside a flush, and never while
    // reset is held (so stall stays low during reset).
    assign accept = rst && (state == S_IDLE) && req_valid_i && !flush_i;

`ifdef MULDIV_DIV0_SHORTCUT_EN
    assign div0 = req_op_i[2] && (req_b_i == 32'd0);
`else
    assign div0 = 1'b0;
`endif

    // A flush in the DONE cycle kills the result, so the valid flag is gated late.
    assign result_valid_o = valid_q && !flush_i;

    // Stall decode: the accepting cycle already holds the pipeline, and while
    // draining we hold only if a new request is trying to get in.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            S_IDLE:          stall_o = accept;
            S_ISSUE, S_WAIT: stall_o = 1'b1;
            S_DRAIN:         stall_o = req_valid_i;
            default:         stall_o = 1'b0;
        endcase
    end

    // Main sequencer: state, operand registers, start pulse, result and watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            wdog         <= 6'd0;
            valid_q      <= 1'b0;
            unit_start_o <= 1'b0;
            unit_op_o    <= 3'd0;
            unit_a_o     <= 32'd0;
            unit_b_o     <= 32'd0;
            result_o     <= 32'd0;
            timeout_o    <= 1'b0;
        end else begin
            unit_start_o <= 1'b0;
            valid_q      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        unit_op_o <= req_op_i;
                        unit_a_o  <= req_a_i;
                        unit_b_o  <= req_b_i;
                        if (div0) begin
                            result_o <= req_op_i[1] ? req_a_i : 32'hFFFF_FFFF;
                            valid_q  <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        unit_start_o <= 1'b1;
                        wdog         <= 6'd0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        // A done arriving with the flush is already consumed,
                        // so there is nothing left to drain.
                        wdog  <= 6'd0;
                        state <= unit_done_i ? S_IDLE : S_DRAIN;
                    end else if (unit_done_i) begin
                        result_o <= unit_result_i;
                        valid_q  <= 1'b1;
                        state    <= S_DONE;
                    end else if (wdog == WDOG_LAST) begin
                        wdog      <= wdog + 6'd1;
                        timeout_o <= 1'b1;
                        result_o  <= 32'd0;
                        valid_q   <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wdog <= wdog + 6'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (unit_done_i) begin
                        state <= S_IDLE;
                    end else if (wdog == WDOG_LAST) begin
                        wdog      <= wdog + 6'd1;
                        timeout_o <= 1'b1;
                        result_o  <= 32'd0;
                        state     <= S_IDLE;
                    end else begin
                        wdog <= wdog + 6'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. A behavioural mul/div
// unit answers start pulses after a chosen number of cycles with RISC-V
// M-extension results; transactions are checked for result, latency,
// stall cycles and start count, plus hand-written flush/timeout/reset cases.
// Honours MULDIV_DIV0_SHORTCUT_EN when the design is built with it.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic [2:0]  req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic        flush_i;
    logic        unit_start_o;
    logic [2:0]  unit_op_o;
    logic [31:0] unit_a_o;
    logic [31:0] unit_b_o;
    logic        unit_done_i;
    logic [31:0] unit_result_i;
    logic        stall_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic        timeout_o;

    muldiv_seq dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_op_i       (req_op_i),
        .req_a_i        (req_a_i),
        .req_b_i        (req_b_i),
        .flush_i        (flush_i),
        .unit_start_o   (unit_start_o),
        .unit_op_o      (unit_op_o),
        .unit_a_o       (unit_a_o),
        .unit_b_o       (unit_b_o),
        .unit_done_i    (unit_done_i),
        .unit_result_i  (unit_result_i),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .timeout_o      (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] exp_res;
    } vec_t;

    int          n_tests;
    int          n_fail;
    int          cyc;
    bit          unit_pending;
    bit          unit_hang;
    bit          force_done;
    bit          exp_timeout;
    int          unit_lat;
    int          unit_pend_lat;
    int          unit_start_cyc;
    int          start_cyc;
    int          done_cyc;
    int          start_count;
    int          valid_count;
    logic [31:0] unit_res;
    logic        o_stall;
    logic        o_valid;
    logic        o_start;
    logic        o_timeout;
    logic [2:0]  o_op;
    logic [31:0] o_result;
    logic [31:0] o_a;
    logic [31:0] o_b;

    // RISC-V M-extension semantics computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_m(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (op)
            3'd0: begin p = longint'(sa * sb); return p[31:0]; end
            3'd1: begin p = longint'(sa * sb); return p[63:32]; end
            3'd2: begin p = longint'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = longint'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = longint'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, let the unit model
    // answer, then sample every output at the falling edge.
    task automatic apply_stimulus(input logic rv, input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic fl);
        @(posedge clk);
        #1;
        cyc++;
        req_valid_i = rv;
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        flush_i     = fl;
        if (unit_pending && !unit_hang && cyc == unit_start_cyc + unit_pend_lat) begin
            unit_done_i   = 1'b1;
            unit_result_i = unit_res;
            unit_pending  = 1'b0;
            done_cyc      = cyc;
        end else begin
            unit_done_i   = force_done;
            unit_result_i = $urandom;
        end
        @(negedge clk);
        o_stall   = stall_o;
        o_valid   = result_valid_o;
        o_start   = unit_start_o;
        o_timeout = timeout_o;
        o_op      = unit_op_o;
        o_result  = result_o;
        o_a       = unit_a_o;
        o_b       = unit_b_o;
        if (result_valid_o) valid_count++;
        if (unit_start_o) begin
            unit_pending   = 1'b1;
            unit_start_cyc = cyc;
            unit_pend_lat  = unit_lat;
            unit_res       = ref_m(unit_op_o, unit_a_o, unit_b_o);
            start_count++;
            start_cyc      = cyc;
        end
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
    endtask

    // Run idle cycles until a result appears or the budget runs out.
    task automatic wait_valid(input int bound, output int n, output bit got, output int stalls);
        n = 0;
        got = 1'b0;
        stalls = 0;
        while (!got && n < bound) begin
            idle_cycle();
            n++;
            if (o_valid) got = 1'b1;
            else stalls += int'(o_stall);
        end
    endtask

    // One complete transaction from request to result, checked end to end.
    task automatic run_txn(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input logic [31:0] exp_res);
        int n;
        int stalls;
        int acc_stall;
        int s0;
        int exp_lat;
        int exp_starts;
        bit got;
        unit_lat   = lat;
        s0         = start_count;
        exp_lat    = lat + 3;
        exp_starts = 1;
`ifdef MULDIV_DIV0_SHORTCUT_EN
        if (op[2] && b == 32'd0) begin
            exp_lat    = 1;
            exp_starts = 0;
        end
`endif
        apply_stimulus(1'b1, op, a, b, 1'b0);
        acc_stall = int'(o_stall);
        wait_valid(exp_lat + 20, n, got, stalls);
        check_output({tag, "_done"}, 32'(got), 32'd1);
        check_output({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check_output({tag, "_result"}, o_result, exp_res);
        check_output({tag, "_stall_cycles"}, 32'(acc_stall + stalls), 32'(exp_lat));
        check_output({tag, "_starts"}, 32'(start_count - s0), 32'(exp_starts));
        check_output({tag, "_timeout"}, 32'(o_timeout), 32'(exp_timeout));
        idle_cycle();
        check_output({tag, "_valid_one_cycle"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] global time limit reached");
    end

    initial begin
        vec_t        vecs[13];
        int          n;
        int          stalls;
        int          v0;
        int          s0;
        int          drain_done;
        bit          got;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] r0;

        n_tests = 0; n_fail = 0; cyc = 0;
        unit_pending = 0; unit_hang = 0; force_done = 0; exp_timeout = 0;
        unit_lat = 1; unit_pend_lat = 1; unit_start_cyc = 0; start_cyc = 0; done_cyc = 0;
        start_count = 0; valid_count = 0; unit_res = 32'd0;
        req_valid_i = 0; req_op_i = 0; req_a_i = 0; req_b_i = 0; flush_i = 0;
        unit_done_i = 0; unit_result_i = 0;

        vecs[0]  = '{3'd0, 32'd6,          32'd7,          4, 32'd42};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFF,  32'd3,          1, 32'hFFFF_FFFD};
        vecs[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  3, 32'h4000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  2, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5, 32'hFFFF_FFFE};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          6, 32'hFFFF_FFFD};
        vecs[6]  = '{3'd5, 32'd100,        32'd0,          3, 32'hFFFF_FFFF};
        vecs[7]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          2, 32'hFFFF_FFFF};
        vecs[8]  = '{3'd7, 32'd100,        32'd7,          4, 32'd2};
        vecs[9]  = '{3'd6, 32'h1234,       32'd0,          2, 32'h1234};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  3, 32'h8000_0000};
        vecs[11] = '{3'd4, 32'h1234_5678,  32'd0,          1, 32'hFFFF_FFFF};
        vecs[12] = '{3'd7, 32'hCAFE_F00D,  32'd0,          2, 32'hCAFE_F00D};

        // Reset held with a request pending: everything must read zero.
        rst = 1'b1;
        #2 rst = 1'b0;
        apply_stimulus(1'b1, 3'd3, 32'h1111_2222, 32'h3333_4444, 1'b0);
        apply_stimulus(1'b1, 3'd3, 32'h1111_2222, 32'h3333_4444, 1'b0);
        check_output("reset_stall", 32'(o_stall), 32'd0);
        check_output("reset_start", 32'(o_start), 32'd0);
        check_output("reset_valid", 32'(o_valid), 32'd0);
        check_output("reset_result", o_result, 32'd0);
        check_output("reset_timeout", 32'(o_timeout), 32'd0);
        check_output("reset_operands", {29'd0, o_op} | o_a | o_b, 32'd0);
        req_valid_i = 1'b0;
        rst = 1'b1;
        idle_cycle();

        // Directed vectors.
        for (int i = 0; i < 13; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].lat, vecs[i].exp_res);
        end

        // Randomized transactions against the reference arithmetic.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_txn($sformatf("rnd%0d", i), rop, ra, rb, $urandom_range(1, 10), ref_m(rop, ra, rb));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
        end

        // Request and flush together in IDLE: nothing is taken.
        v0 = valid_count; s0 = start_count;
        apply_stimulus(1'b1, 3'd0, 32'd3, 32'd4, 1'b1);
        check_output("idle_flush_stall", 32'(o_stall), 32'd0);
        idle_cycle();
        check_output("idle_flush_stall_next", 32'(o_stall), 32'd0);
        for (int i = 0; i < 3; i++) idle_cycle();
        check_output("idle_flush_starts", 32'(start_count - s0), 32'd0);
        check_output("idle_flush_valids", 32'(valid_count - v0), 32'd0);

        // Flush in ISSUE: the unit is never started.
        v0 = valid_count; s0 = start_count;
        unit_lat = 2;
        apply_stimulus(1'b1, 3'd0, 32'd5, 32'd5, 1'b0);
        apply_stimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) idle_cycle();
        check_output("issue_flush_starts", 32'(start_count - s0), 32'd0);
        check_output("issue_flush_valids", 32'(valid_count - v0), 32'd0);
        check_output("issue_flush_stall", 32'(o_stall), 32'd0);

        // Flush in WAIT, unit answers 3 cycles later, next request held high.
        v0 = valid_count; s0 = start_count;
        unit_lat = 4;
        apply_stimulus(1'b1, 3'd0, 32'd11, 32'd13, 1'b0);
        idle_cycle();
        idle_cycle();
        apply_stimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 3'd3, 32'h8000_0000, 32'd4, 1'b0);
            check_output($sformatf("drain_stall%0d", i), 32'(o_stall), 32'd1);
        end
        drain_done = done_cyc;
        apply_stimulus(1'b1, 3'd3, 32'h8000_0000, 32'd4, 1'b0);
        check_output("drain_accept_stall", 32'(o_stall), 32'd1);
        idle_cycle();
        idle_cycle();
        check_output("drain_second_start_cycle", 32'(start_cyc - drain_done), 32'd3);
        wait_valid(30, n, got, stalls);
        check_output("drain_second_done", 32'(got), 32'd1);
        check_output("drain_second_result", o_result, 32'd2);
        check_output("drain_valids", 32'(valid_count - v0), 32'd1);
        check_output("drain_starts", 32'(start_count - s0), 32'd2);

        // Flush in DONE: the result is suppressed.
        v0 = valid_count;
        unit_lat = 2;
        apply_stimulus(1'b1, 3'd0, 32'd9, 32'd9, 1'b0);
        idle_cycle();
        idle_cycle();
        idle_cycle();
        idle_cycle();
        check_output("done_flush_prev_stall", 32'(o_stall), 32'd1);
        apply_stimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check_output("done_flush_valid", 32'(o_valid), 32'd0);
        check_output("done_flush_stall", 32'(o_stall), 32'd0);
        idle_cycle();
        idle_cycle();
        check_output("done_flush_valids", 32'(valid_count - v0), 32'd0);

        // Done pulses while idle are ignored.
        v0 = valid_count; s0 = start_count;
        r0 = o_result;
        force_done = 1'b1;
        idle_cycle();
        idle_cycle();
        force_done = 1'b0;
        idle_cycle();
        check_output("spurious_done_valids", 32'(valid_count - v0), 32'd0);
        check_output("spurious_done_result", o_result, r0);

        // Unit never answers: watchdog fires after 63 waiting cycles.
        v0 = valid_count;
        unit_hang = 1'b1;
        apply_stimulus(1'b1, 3'd0, 32'd9, 32'd9, 1'b0);
        wait_valid(100, n, got, stalls);
        check_output("timeout_done", 32'(got), 32'd1);
        check_output("timeout_latency", 32'(n), 32'd65);
        check_output("timeout_result", o_result, 32'd0);
        check_output("timeout_flag", 32'(o_timeout), 32'd1);
        idle_cycle();
        check_output("timeout_valid_once", 32'(valid_count - v0), 32'd1);
        unit_hang = 1'b0;
        unit_pending = 1'b0;
        exp_timeout = 1'b1;
        run_txn("after_timeout", 3'd0, 32'd2, 32'd3, 2, 32'd6);

        // Reset during WAIT, then a late done from the unit.
        v0 = valid_count; s0 = start_count;
        unit_lat = 5;
        apply_stimulus(1'b1, 3'd3, 32'h55, 32'h66, 1'b0);
        idle_cycle();
        idle_cycle();
        idle_cycle();
        rst = 1'b0;
        idle_cycle();
        check_output("midreset_stall", 32'(o_stall), 32'd0);
        check_output("midreset_timeout", 32'(o_timeout), 32'd0);
        check_output("midreset_operands", {29'd0, o_op} | o_a | o_b, 32'd0);
        check_output("midreset_result", o_result, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) idle_cycle();
        exp_timeout = 1'b0;
        check_output("midreset_valids", 32'(valid_count - v0), 32'd0);
        check_output("midreset_result_after", o_result, 32'd0);
        check_output("midreset_stall_after", 32'(o_stall), 32'd0);
        check_output("midreset_starts", 32'(start_count - s0), 32'd1);
        run_txn("after_reset", 3'd5, 32'd100, 32'd7, 3, 32'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
